icap_emu: RTL

ICAP_EMU -- requirements
Module: icap_emu

---
 rtl/icap_emu_pkg.sv | 33 +++
 rtl/icap_pkt_decode.sv | 30 +++
 rtl/icap_emu.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/icap_emu_pkg.sv
// Shared constants and state type for the ICAP configuration-port emulator.
// Holds the special configuration words, register addresses, CMD codes and packet field codes.
`timescale 1ns/1ps
package icap_emu_pkg;

    localparam logic [31:0] SYNC_WORD      = 32'hAA995566;
    localparam logic [31:0] NOP_WORD       = 32'h20000000;
    localparam logic [31:0] DUMMY_WORD     = 32'hFFFFFFFF;
    localparam logic [31:0] BUS_WIDTH_SYNC = 32'h000000BB;
    localparam logic [31:0] BUS_WIDTH_DET  = 32'h11220044;

    localparam logic [4:0] REG_FDRI   = 5'h02;
    localparam logic [4:0] REG_CMD    = 5'h04;
    localparam logic [4:0] REG_STAT   = 5'h07;
    localparam logic [4:0] REG_IDCODE = 5'h0C;

    localparam logic [4:0] CMD_DESYNC = 5'h0D;

    localparam logic [2:0] PKT_TYPE1 = 3'b001;
    localparam logic [2:0] PKT_TYPE2 = 3'b010;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        HDR    = 2'd1,
        WDATA  = 2'd2,
        RDATA  = 2'd3
    } state_t;

endpackage

// File: rtl/icap_pkt_decode.sv
// Combinational parser for configuration packet headers.
// Type-1 carries an 11-bit word count, type-2 a 27-bit one; other types are flagged invalid.
`timescale 1ns/1ps
module icap_pkt_decode
    import icap_emu_pkg::*;
(
    input  logic [31:0] word,
    output logic [2:0]  pkt_type,
    output logic [1:0]  op,
    output logic [4:0]  reg_addr,
    output logic [26:0] cnt,
    output logic        valid
);

    always_comb begin
        pkt_type = word[31:29];
        op       = word[28:27];
        reg_addr = word[17:13];
        cnt      = '0;
        valid    = 1'b0;
        if (word[31:29] == PKT_TYPE1) begin
            cnt   = {16'b0, word[10:0]};
            valid = 1'b1;
        end else if (word[31:29] == PKT_TYPE2) begin
            cnt   = word[26:0];
            valid = 1'b1;
        end
    end

endmodule

// File: rtl/icap_emu.sv
// Behavioural emulator of an ICAP configuration port: sync detection, packet parsing,
// IDCODE/FDRI/CMD register effects, STAT/IDCODE readback and sticky done/error flags.
`timescale 1ns/1ps
module icap_emu
    import icap_emu_pkg::*;
#(
    parameter logic [31:0] IDCODE      = 32'h14B31093,
    parameter int unsigned AVAIL_DELAY = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csib,
    input  logic        rdwrb,
    input  logic [31:0] i,
    output logic [31:0] o,
    output logic        avail,
    output logic        prdone,
    output logic        prerror,
    output logic [31:0] fdri_count
);

    state_t      state, state_n;
    logic [26:0] cnt, cnt_n;
    logic [4:0]  cur_reg, reg_n;
    logic        desync_pend, desync_n;
    logic        id_ok, id_ok_n;
    logic        prdone_n, prerror_n;
    logic [31:0] fdri_n, o_n;
    logic [31:0] avail_cnt;
    logic        prev_active, prev_rdwrb;

    logic [2:0]  dec_type;
    logic [1:0]  dec_op;
    logic [4:0]  dec_reg;
    logic [26:0] dec_cnt;
    logic        dec_valid;

    logic        beat_active, toggle_err, is_sync, write_beat, read_beat, hdr_decode;
    logic [31:0] rd_val;

    icap_pkt_decode u_decode (
        .word     (i),
        .pkt_type (dec_type),
        .op       (dec_op),
        .reg_addr (dec_reg),
        .cnt      (dec_cnt),
        .valid    (dec_valid)
    );

    // A direction change on back-to-back selected cycles is a protocol error and is otherwise dropped.
    assign beat_active = ~csib & avail;
    assign toggle_err  = beat_active & prev_active & (rdwrb != prev_rdwrb);
    assign is_sync     = beat_active & ~rdwrb & (i == SYNC_WORD);
    assign write_beat  = beat_active & ~rdwrb & ~toggle_err;
    assign read_beat   = beat_active & rdwrb & ~toggle_err;

    always_comb begin
        rd_val = '0;
        unique case (cur_reg)
            REG_IDCODE: rd_val = IDCODE;
            REG_STAT:   rd_val = {27'b0, prdone, prerror, id_ok, 1'b1, avail};
            default:    rd_val = '0;
        endcase
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        reg_n      = cur_reg;
        desync_n   = desync_pend;
        prdone_n   = prdone;
        prerror_n  = prerror;
        id_ok_n    = id_ok;
        fdri_n     = fdri_count;
        o_n        = '0;
        hdr_decode = 1'b0;

        // Sync resynchronises from anywhere and wins over any error raised in the same beat.
        if (is_sync) begin
            state_n   = HDR;
            cnt_n     = '0;
            desync_n  = 1'b0;
            prdone_n  = 1'b0;
            prerror_n = 1'b0;
            id_ok_n   = 1'b0;
            fdri_n    = '0;
        end else if (toggle_err) begin
            prerror_n = 1'b1;
        end else begin
            unique case (state)
                UNSYNC: ;
                HDR:    hdr_decode = write_beat;
                WDATA: begin
                    if (write_beat) begin
                        cnt_n = cnt - 27'd1;
                        unique case (cur_reg)
                            REG_CMD: begin
                                if (i[4:0] == CMD_DESYNC) begin
                                    desync_n = 1'b1;
                                    if (!prerror) prdone_n = 1'b1;
                                end
                            end
                            REG_IDCODE: begin
                                if (i == IDCODE) id_ok_n = 1'b1;
                                else             prerror_n = 1'b1;
                            end
                            REG_FDRI: begin
                                if (fdri_count != 32'hFFFFFFFF) fdri_n = fdri_count + 32'd1;
                                if (!id_ok) prerror_n = 1'b1;
                            end
                            default: ;
                        endcase
                        if (cnt == 27'd1) begin
                            state_n  = desync_n ? UNSYNC : HDR;
                            desync_n = 1'b0;
                        end
                    end
                end
                RDATA: begin
                    if (write_beat) begin
                        hdr_decode = 1'b1;
                    end else if (read_beat) begin
                        o_n   = rd_val;
                        cnt_n = cnt - 27'd1;
                        if (cnt == 27'd1) state_n = HDR;
                    end
                end
            endcase

            if (hdr_decode) begin
                state_n = HDR;
                if (i == DUMMY_WORD) begin
                    // dummy padding is a NOP even though its type field is not 1 or 2
                end else if (!dec_valid) begin
                    prerror_n = 1'b1;
                end else begin
                    // A bare NOP must not clobber the register a following type-2 header relies on.
                    if (dec_type == PKT_TYPE1 && dec_op != OP_NOP) reg_n = dec_reg;
                    cnt_n = dec_cnt;
                    if (dec_cnt != 27'd0) begin
                        if (dec_op == OP_WRITE)     state_n = WDATA;
                        else if (dec_op == OP_READ) state_n = RDATA;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= UNSYNC;
            cnt         <= '0;
            cur_reg     <= '0;
            desync_pend <= 1'b0;
            prdone      <= 1'b0;
            prerror     <= 1'b0;
            id_ok       <= 1'b0;
            fdri_count  <= '0;
            o           <= '0;
            avail       <= 1'b0;
            avail_cnt   <= '0;
            prev_active <= 1'b0;
            prev_rdwrb  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            cur_reg     <= reg_n;
            desync_pend <= desync_n;
            prdone      <= prdone_n;
            prerror     <= prerror_n;
            id_ok       <= id_ok_n;
            fdri_count  <= fdri_n;
            o           <= o_n;
            prev_active <= beat_active;
            if (beat_active) prev_rdwrb <= rdwrb;
            if (!avail) begin
                if (avail_cnt == AVAIL_DELAY - 1) avail <= 1'b1;
                avail_cnt <= avail_cnt + 32'd1;
            end
        end
    end

endmodule
